// File: rtl/nn_pkg.sv
// ----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the neuron datapath blocks.
//   DATA_WIDTH / FRAC_BITS : default fixed-point format of x, w, bias, output
//   data_t                 : signed DATA_WIDTH data word
//   neuron_state_e         : control states of neuron_mac_seq
//   sat_trunc()            : arithmetic shift right by FRAC_BITS, then saturate
//                            to the data_t range
// sat_trunc() is written against the package constants. Instances of
// neuron_mac_seq must keep DATA_WIDTH/FRAC_BITS equal to these values.
// ----------------------------------------------------------------------------
package nn_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 12;
  // Fixed, generous input width so one function serves any accumulator size.
  localparam int SAT_IN_W   = 64;

  typedef logic signed [DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    FINAL,
    OUT
  } neuron_state_e;

  localparam logic signed [SAT_IN_W-1:0] SAT_MAX = (64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1;
  localparam logic signed [SAT_IN_W-1:0] SAT_MIN = -(64'sd1 <<< (DATA_WIDTH-1));

  // The shift floors toward -inf because it is arithmetic on a signed value.
  function automatic data_t sat_trunc(input logic signed [SAT_IN_W-1:0] v);
    logic signed [SAT_IN_W-1:0] s;
    s = v >>> FRAC_BITS;
    if (s > SAT_MAX)
      sat_trunc = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (s < SAT_MIN)
      sat_trunc = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      sat_trunc = s[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/neuron_mac_pipe.sv
// ----------------------------------------------------------------------------
// neuron_mac_pipe
// Three-stage multiply/accumulate pipe with a valid chain.
//   stage1: capture the accepted activation (the ROM read is issued in the
//           same cycle)
//   stage2: multiply it by the ROM word, which arrives one cycle later
//   stage3: accumulate the sign-extended product
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_accept    activation handshake fired this cycle
//   i_x         activation, signed
//   i_w         weight ROM data, valid one cycle after i_accept
//   i_clr       clear the accumulator (result consumed)
//   o_v1, o_v2  stage1 / stage2 valid flags
//   o_acc       running sum of products
// ----------------------------------------------------------------------------
module neuron_mac_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 37
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_accept,
  input  logic signed [DATA_WIDTH-1:0] i_x,
  input  logic signed [DATA_WIDTH-1:0] i_w,
  input  logic                         i_clr,
  output logic                         o_v1,
  output logic                         o_v2,
  output logic signed [ACC_WIDTH-1:0]  o_acc
);
  import nn_pkg::*;

  logic signed [DATA_WIDTH-1:0]   r_x;
  logic signed [2*DATA_WIDTH-1:0] r_prod;
  logic                           r_v1;
  logic                           r_v2;
  logic signed [ACC_WIDTH-1:0]    r_acc;

  // NOTE: r_x and r_prod carry no reset; they are only consumed when their
  // valid flag is set, and the valid flags are reset.
  always_ff @(posedge clk) begin
    if (i_accept) r_x <= i_x;
    r_prod <= r_x * i_w;
  end

  // NOTE: all sequential state uses non-blocking assignments so every stage
  // sees the previous cycle's value of the stage before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_acc <= '0;
    end else begin
      r_v1 <= i_accept;
      r_v2 <= r_v1;
      if (i_clr)
        r_acc <= '0;
      else if (r_v2)
        r_acc <= r_acc + ACC_WIDTH'(r_prod);
    end
  end

  assign o_v1  = r_v1;
  assign o_v2  = r_v2;
  assign o_acc = r_acc;

endmodule

// File: rtl/neuron_mac_seq.sv
// ----------------------------------------------------------------------------
// neuron_mac_seq
// Sequential neuron: takes NUM_WEIGHT serial activations, reads the matching
// weights from a 1-cycle-latency ROM, forms sum(x*w) + BIAS and presents one
// saturated, registered result per frame over valid/ready.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    activation handshake, in_data = activation (signed)
//   w_ren/w_radd/w_data  weight ROM read port (data one cycle after w_ren)
//   out_valid/out_ready  result handshake, out_data = neuron output (signed)
// Optional feature: define NEURON_RELU_EN to apply ReLU after saturation;
// otherwise the saturated value is passed through unchanged.
// ----------------------------------------------------------------------------
module neuron_mac_seq #(
  parameter int                          NUM_WEIGHT = 30,
  parameter int                          ADDR_WIDTH = $clog2(NUM_WEIGHT),
  parameter int                          DATA_WIDTH = 16,
  parameter int                          FRAC_BITS  = 12,
  parameter logic signed [DATA_WIDTH-1:0] BIAS      = 16'sh0000,
  parameter int                          ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic                         w_ren,
  output logic        [ADDR_WIDTH-1:0] w_radd,
  input  logic signed [DATA_WIDTH-1:0] w_data,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  input  logic                         out_ready
);
  import nn_pkg::*;

  neuron_state_e                r_state;
  logic [ADDR_WIDTH-1:0]        r_cnt;
  logic                         r_out_valid;
  logic signed [DATA_WIDTH-1:0] r_out_data;

  logic                         w_accept;
  logic                         w_clr;
  logic                         w_v1;
  logic                         w_v2;
  logic signed [ACC_WIDTH-1:0]  w_acc;
  logic signed [ACC_WIDTH-1:0]  w_bias_ext;
  logic signed [ACC_WIDTH-1:0]  w_sum;
  data_t                        w_sat;
  data_t                        w_act;

  assign in_ready = (r_state == RUN);
  assign w_accept = in_valid && in_ready;
  assign w_ren    = w_accept;
  assign w_radd   = r_cnt;
  // Result is consumed: wipe the accumulator for the next frame.
  assign w_clr    = (r_state == OUT) && out_ready;

  neuron_mac_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_accept (w_accept),
    .i_x      (in_data),
    .i_w      (w_data),
    .i_clr    (w_clr),
    .o_v1     (w_v1),
    .o_v2     (w_v2),
    .o_acc    (w_acc)
  );

  // Bias is aligned to the product scale (2*FRAC_BITS fractional bits) before
  // the final shift back to the data format.
  assign w_bias_ext = ACC_WIDTH'(BIAS) <<< FRAC_BITS;
  assign w_sum      = w_acc + w_bias_ext;
  assign w_sat      = sat_trunc(SAT_IN_W'(w_sum));

`ifdef NEURON_RELU_EN
  assign w_act = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
  assign w_act = w_sat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_accept) begin
            if (r_cnt == ADDR_WIDTH'(NUM_WEIGHT-1)) begin
              r_cnt   <= '0;
              r_state <= DRAIN;
            end else begin
              r_cnt <= r_cnt + ADDR_WIDTH'(1);
            end
          end
        end
        // Both pipe stages empty means the last product is in the accumulator.
        DRAIN: if (!w_v1 && !w_v2) r_state <= FINAL;
        FINAL: begin
          r_out_data  <= w_act;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// ----------------------------------------------------------------------------
// tb_neuron_mac_seq
// Directed bench for neuron_mac_seq. Two instances share all stimulus: dut
// uses the default BIAS (0), dut_b uses BIAS = 1.0 (0x1000). Each has its own
// 1-cycle registered model of the weight ROM, both reading one table.
// ----------------------------------------------------------------------------
module tb_neuron_mac_seq;

  localparam int NW = 30;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        in_ready,  in_ready_b;
  logic        w_ren,     w_ren_b;
  logic [4:0]  w_radd,    w_radd_b;
  logic [15:0] w_data,    w_data_b;
  logic        out_valid, out_valid_b;
  logic [15:0] out_data,  out_data_b;

  logic [15:0] rom [NW];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  neuron_mac_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .w_ren     (w_ren),
    .w_radd    (w_radd),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  neuron_mac_seq #(.BIAS(16'sh1000)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready_b),
    .w_ren     (w_ren_b),
    .w_radd    (w_radd_b),
    .w_data    (w_data_b),
    .out_valid (out_valid_b),
    .out_data  (out_data_b),
    .out_ready (out_ready)
  );

  always @(posedge clk) begin
    if (w_ren)   w_data   <= rom[w_radd];
    if (w_ren_b) w_data_b <= rom[w_radd_b];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_rom(input logic [15:0] w);
    for (int i = 0; i < NW; i++) rom[i] = w;
  endtask

  // Offer n activations; every issued ROM read must hit the next address.
  task automatic send_frame(input logic [15:0] x, input bit bubbles, input int n);
    int sent = 0;
    int cyc  = 0;
    while (sent < n && cyc < 400) begin
      @(negedge clk);
      in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = x;
      #1;
      if (w_ren) begin
        check("w_radd", 32'(w_radd), 32'(sent));
        sent++;
      end
      cyc++;
    end
    check("frame_accepts", 32'(sent), 32'(n));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Entered 1 time unit after the last accepting edge.
  task automatic wait_result(input string tag, input logic [15:0] exp, input logic [15:0] exp_b);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_data"},    32'(out_data), 32'(exp));
    check({tag, "_valid_b"}, 32'(out_valid_b), 32'd1);
    check({tag, "_data_b"},  32'(out_data_b), 32'(exp_b));
  endtask

  task automatic hold_result(input int cycles);
    logic [15:0] held;
    bit          ok = 1'b1;
    held = out_data;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      #1;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || w_ren !== 1'b0)
        ok = 1'b0;
    end
    check("hold_stable", 32'(ok), 32'd1);
  endtask

  task automatic release_result();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_neg, exp_neg_b, exp_msat;
`ifdef NEURON_RELU_EN
    exp_neg   = 16'h0000;
    exp_neg_b = 16'h0000;
    exp_msat  = 16'h0000;
`else
    exp_neg   = 16'hC400;  // -3.75
    exp_neg_b = 16'hD400;  // -3.75 + 1.0 = -2.75
    exp_msat  = 16'h8000;
`endif
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    load_rom(16'h0800);
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_in_ready_b", 32'(in_ready_b), 32'd1);
    check("rst_w_ren",     32'(w_ren), 32'd0);
    rst_n = 1'b1;

    // 0.25 * 0.5 * 30 = 3.75; with bias 4.75.
    send_frame(16'h0400, 1'b0, NW);
    wait_result("c1", 16'h3C00, 16'h4C00);
    hold_result(20);
    release_result();

    // -0.25 * 0.5 * 30 = -3.75.
    send_frame(16'hFC00, 1'b0, NW);
    wait_result("c2", exp_neg, exp_neg_b);
    release_result();

    // 1.0 * 1.0 * 30 = 30.0 saturates high.
    load_rom(16'h1000);
    send_frame(16'h1000, 1'b0, NW);
    wait_result("c3", 16'h7FFF, 16'h7FFF);
    release_result();

    // -1.0 * 1.0 * 30 = -30.0 saturates low.
    load_rom(16'hF000);
    send_frame(16'h1000, 1'b0, NW);
    wait_result("c4", exp_msat, exp_msat);
    release_result();

    // Case 1 again with random input bubbles.
    load_rom(16'h0800);
    send_frame(16'h0400, 1'b1, NW);
    wait_result("c5", 16'h3C00, 16'h4C00);
    release_result();

    // Reset mid-frame, then a clean frame of zero activations.
    send_frame(16'h0400, 1'b0, 10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_data",   32'(out_data), 32'd0);
    check("midrst_out_valid",  32'(out_valid), 32'd0);
    check("midrst_out_data_b", 32'(out_data_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(16'h0000, 1'b0, NW);
    wait_result("c6", 16'h0000, 16'h1000);
    release_result();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
